// File: rtl/alu_result_latch_pkg.sv
// alu_pkg: shared constants and types for the ALU result latch.
//   DATA_W : width of the ALU result held by the latch
//   DEPTH  : number of history entries (power of two)
//   PTR_W  : index width for the history ring, log2(DEPTH)
//   CNT_W  : width of the valid-entry count, which must hold 0..DEPTH
//   cap_state_e : capture FSM states
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // S_HELD is the reset state. It waits for load to drop so that one press
  // produces exactly one capture.
  typedef enum logic {
    S_HELD  = 1'b0,
    S_ARMED = 1'b1
  } cap_state_e;

endpackage

// File: rtl/alu_result_latch_if.sv
// alu_result_latch_if: bundle between the ALU/user controls and the result latch.
//   alu_out    : combinational ALU result (to latch)
//   load       : level capture request, one capture per rising level
//   clear      : synchronous clear of result, history and flags
//   view_step  : advance the history view by one entry per cycle high
//   result     : current registered result
//   b_feedback : result[3:0], the ALU's B operand
//   view_data  : history entry currently being viewed (0 when empty)
//   view_idx   : view offset, 0 is the newest entry
//   count      : number of valid history entries
//   ovf        : sticky flag, a capture overwrote the oldest entry
// The master modport drives the requests; the slave modport is the latch.
interface alu_result_latch_if #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEPTH  = alu_pkg::DEPTH
);
  import alu_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] alu_out;
  logic              load;
  logic              clear;
  logic              view_step;
  logic [DATA_W-1:0] result;
  logic [3:0]        b_feedback;
  logic [DATA_W-1:0] view_data;
  logic [IDX_W-1:0]  view_idx;
  logic [IDX_W:0]    count;
  logic              ovf;

  modport master (
    output alu_out, load, clear, view_step,
    input  result, b_feedback, view_data, view_idx, count, ovf
  );

  modport slave (
    input  alu_out, load, clear, view_step,
    output result, b_feedback, view_data, view_idx, count, ovf
  );

endinterface

// File: rtl/alu_result_latch_history.sv
// result_history: DEPTH x DATA_W ring buffer of captured results.
//   clk, reset_n : clock and synchronous active-low reset
//   clear        : zero every entry, pointer, count, view offset and ovf
//   capture      : store din at wr_ptr this edge
//   din          : value to store
//   view_step    : advance the view offset, wrapping at count
//   view_data    : entry at view_idx counted back from the newest (0 if empty)
//   view_idx     : registered view offset
//   count        : valid entries, saturates at DEPTH
//   ovf          : sticky, set when a capture replaces the oldest entry
module result_history #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEPTH  = alu_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       capture,
  input  logic [DATA_W-1:0]          din,
  input  logic                       view_step,
  output logic [DATA_W-1:0]          view_data,
  output logic [$clog2(DEPTH)-1:0]   view_idx,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);
  import alu_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  rd_ptr;
  logic [IDX_W:0]    view_next;

  // Extended by one bit so the wrap test against count (which can equal
  // DEPTH) does not overflow.
  assign view_next = {1'b0, view_idx} + (IDX_W+1)'(1);

  // Clear shares the reset path, so it also beats a simultaneous capture.
  // A capture always snaps the view back to the newest entry.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      count    <= '0;
      view_idx <= '0;
      ovf      <= 1'b0;
    end else if (capture) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + IDX_W'(1);
      if (count == FULL) begin
        ovf <= 1'b1;
      end else begin
        count <= count + (IDX_W+1)'(1);
      end
      view_idx <= '0;
    end else if (view_step && (count != '0)) begin
      if (view_next == count) begin
        view_idx <= '0;
      end else begin
        view_idx <= view_idx + IDX_W'(1);
      end
    end
  end

  // wr_ptr points one past the newest entry; the subtraction wraps mod DEPTH.
  always_comb begin
    rd_ptr    = wr_ptr - IDX_W'(1) - view_idx;
    view_data = '0;
    if (count != '0) begin
      view_data = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/alu_result_latch.sv
// alu_result_latch: registered result stage behind the lab ALU.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   bus     : alu_result_latch_if slave (ALU result in, load/clear/view
//             controls in, result, B feedback and history view out)
// A capture FSM turns the level load request into one capture per press.
// The captured value becomes the result and is pushed into the history.
module alu_result_latch #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEPTH  = alu_pkg::DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_result_latch_if.slave   bus
);
  import alu_pkg::*;

  cap_state_e        state;
  cap_state_e        state_next;
  logic              capture;
  logic [DATA_W-1:0] result_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_HELD;
    end else begin
      state <= state_next;
    end
  end

  // Reset lands in S_HELD, so a load held through reset must be released
  // before anything is captured. Clear is deliberately not looked at here:
  // a clear colliding with a capture still leaves the FSM in S_HELD.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      S_HELD: begin
        if (!bus.load) begin
          state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (bus.load) begin
          capture    = 1'b1;
          state_next = S_HELD;
        end
      end
      default: state_next = S_HELD;
    endcase
  end

  // The FSM is back in S_HELD when the fed-back B operand changes the ALU
  // output, so the accumulator loop cannot re-capture its own result.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.clear) begin
      result_q <= '0;
    end else if (capture) begin
      result_q <= bus.alu_out;
    end
  end

  assign bus.result     = result_q;
  assign bus.b_feedback = result_q[3:0];

  result_history #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_history (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (bus.clear),
    .capture   (capture),
    .din       (bus.alu_out),
    .view_step (bus.view_step),
    .view_data (bus.view_data),
    .view_idx  (bus.view_idx),
    .count     (bus.count),
    .ovf       (bus.ovf)
  );

endmodule

// File: doc/alu_result_latch.md
# alu_result_latch

Registered result stage directly downstream of the lab 3 combinational ALU. It captures the ALU's 8-bit output on a debounced-level load request and holds it as the current result for LEDR, HEX4 and HEX5. It feeds `result[3:0]` back as the ALU's B operand, which turns the ALU into an accumulator. It also keeps a 4-deep history of captured results that the user steps through on a spare HEX pair.

## Interface
- `DATA_W`, default 8: result width; must match the ALU output width.
- `DEPTH`, default 4: number of history entries; must be a power of two.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `alu_out`  in  DATA_W  combinational ALU result.
- `load`  in  1  active-high level capture request; one capture per low→high transition.
- `clear`  in  1  active-high synchronous clear of result, history and flags.
- `view_step`  in  1  active-high single-cycle pulse; advances the history view by one entry.
- `result`  out  DATA_W  current registered result.
- `b_feedback`  out  4  equals `result[3:0]`; drives the ALU's B operand.
- `view_data`  out  DATA_W  history entry at `view_idx`; `view_idx` 0 is the newest entry.
- `view_idx`  out  log2(DEPTH)  current view offset.
- `count`  out  log2(DEPTH)+1  number of valid history entries, 0..DEPTH.
- `ovf`  out  1  sticky; set when a capture overwrites the oldest entry.

## Operation
- Capture FSM has two states:
  - `S_HELD` (reset state): waits for `load`=0, then moves to `S_ARMED`.
  - `S_ARMED`: when `load`=1, performs a capture and moves to `S_HELD`.
- Resetting into `S_HELD` means a `load` held through reset never triggers a capture.
- A capture does all of the following in one edge:
  - `result` ← `alu_out`.
  - Writes `alu_out` into the history at `wr_ptr`, then `wr_ptr` += 1 mod DEPTH.
  - `count` += 1, saturating at DEPTH.
  - If `count` was already DEPTH, sets `ovf`; the oldest entry is lost.
  - Sets `view_idx` to 0.
- `view_step`:
  - With `count`=0: ignored.
  - Otherwise: `view_idx` ← (`view_idx`+1), wrapping to 0 when it reaches `count`.
- `view_data` = history[(`wr_ptr`−1−`view_idx`) mod DEPTH] when `count`>0, else 0. It is combinational from registered state.
- `clear` zeroes `result`, the history, `count`, `wr_ptr`, `view_idx` and `ovf`. It does not change the FSM state.
- Simultaneous events:
  - `clear` with a capture: `clear` wins, nothing is stored; FSM still goes to `S_HELD`.
  - Capture with `view_step`: capture wins; `view_idx`=0.
- Arithmetic is unsigned; all pointer and index math is modulo DEPTH with no carry out.

## Timing
- Reset values:
  - `result`=0, `b_feedback`=0, `view_data`=0, `view_idx`=0, `count`=0, `ovf`=0.
  - FSM in `S_HELD`; `wr_ptr`=0; history all zeros.
- Capture latency is one edge. `load` is sampled high at edge N while in `S_ARMED`, and `result` shows `alu_out` as sampled at edge N immediately after edge N.
- `b_feedback` changes in the same cycle as `result`. The ALU output therefore changes one cycle after a capture, and the FSM sits in `S_HELD` at that point, so the change cannot be re-captured.
- Minimum spacing between captures is 2 cycles: `load` high, then low, then high.
- `view_step` takes effect on the edge where it is sampled high; a pulse held for k cycles advances the view k times.
- Reset mid-operation (any state, any cycle) returns every register to its reset value on that edge. No partial capture survives.

## Structure
- Package `alu_pkg` holds:
  - `DATA_W` and `DEPTH` constants, and `PTR_W` = log2(DEPTH).
  - The FSM state typedef (`S_HELD`, `S_ARMED`).
- Sub-module `result_history` is the DEPTH×DATA_W ring buffer. It owns:
  - `wr_ptr`, `count`, `ovf`.
  - The registered `view_idx` and the read mux.
- The top level contains the capture FSM and the `result` register.

## Test plan
- Reset with `load`=1 held, then release reset while keeping `load` high for 5 cycles → no capture; `count`=0, `result`=0x00.
- From `S_ARMED`, `alu_out`=0x3C and pulse `load` high → next cycle `result`=0x3C, `b_feedback`=0xC, `count`=1, `view_data`=0x3C.
- Capture 0x01, 0x02, 0x03, 0x04, 0x05 with a release between each → `count`=4, `ovf`=1, `result`=0x05. Stepping the view then yields 0x05, 0x04, 0x03, 0x02, then wraps to 0x05.
- `clear` and a capture of 0x77 in the same cycle → `result`=0x00, `count`=0. A further capture needs a `load` release first.
- With `count`=2, assert `view_step` and a capture of 0x9A in the same cycle → `view_idx`=0, `view_data`=0x9A, `count`=3.
- Assert `reset_n`=0 for 1 cycle with `count`=3, `ovf`=1 → every output reads its reset value on the next cycle.
